// File: rtl/alu_mdu.sv
// EX-stage ALU with valid/ready handshake and iterative unsigned mul/div.
// Single-cycle ops finish in one edge; MULU/DIVU take WIDTH edges.
module alu_mdu #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             zero,
   output logic             ovf,
   output logic             dz,
   output logic             err,
   output logic             busy
);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

   state_t           state, state_nx;
   logic [SHW-1:0]   cnt;
   logic [WIDTH-1:0] opd, hi, lo;

   logic             accept, go_mul, go_div, last, done, ld_single;
   logic [SHW-1:0]   sh;
   logic [WIDTH-1:0] sum, dif;
   logic [WIDTH-1:0] alu_res, alu_hi;
   logic             alu_zero, alu_ovf, alu_dz, alu_err;
   logic [WIDTH:0]   mul_sum, div_sh, div_df;
   logic             div_ok;
   logic [WIDTH-1:0] step_hi, step_lo;

   assign busy     = (state != S_IDLE);
   assign in_ready = (state == S_IDLE) && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign go_mul   = accept && (op == 4'hC);
   assign go_div   = accept && (op == 4'hD) && (b != '0);
   assign last     = (cnt == '0);
   assign done     = busy && last;
   assign ld_single = accept && !go_mul && !go_div;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE: begin
            unique case (1'b1)
               go_mul:  state_nx = S_MUL;
               go_div:  state_nx = S_DIV;
               default: state_nx = S_IDLE;
            endcase
         end
         S_MUL, S_DIV: if (last) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   assign sh  = b[SHW-1:0];
   assign sum = a + b;
   assign dif = a - b;

   always_comb begin
      alu_res = '0;
      alu_hi  = '0;
      alu_ovf = 1'b0;
      alu_dz  = 1'b0;
      alu_err = 1'b0;
      unique case (op)
         4'h0: begin
            alu_res = sum;
            alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         4'h1: begin
            alu_res = dif;
            alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
         end
         4'h2: alu_res = a | b;
         4'h3: alu_res = a & b;
         4'h4: alu_res = a;
         4'h5: alu_res = a ^ b;
         4'h6: alu_res = ~(a | b);
         4'h7: alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
         4'h8: alu_res = {{(WIDTH-1){1'b0}}, a < b};
         4'h9: alu_res = a << sh;
         4'hA: alu_res = a >> sh;
         4'hB: alu_res = $unsigned($signed(a) >>> sh);
         4'hD: begin
            alu_res = '1;
            alu_hi  = a;
            alu_dz  = 1'b1;
         end
         default: alu_err = 1'b1;
      endcase
      alu_zero = (op == 4'h4) ? (a == b) : (alu_res == '0);
   end

   // hi:lo is product/multiplier for MUL, remainder/dividend-quotient for DIV
   always_comb begin
      mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opd} : '0);
      div_sh  = {hi, lo[WIDTH-1]};
      div_df  = div_sh - {1'b0, opd};
      div_ok  = !div_df[WIDTH];
      if (state == S_MUL) begin
         step_hi = mul_sum[WIDTH:1];
         step_lo = {mul_sum[0], lo[WIDTH-1:1]};
      end else begin
         step_hi = div_ok ? div_df[WIDTH-1:0] : div_sh[WIDTH-1:0];
         step_lo = {lo[WIDTH-2:0], div_ok};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         opd       <= '0;
         hi        <= '0;
         lo        <= '0;
         out_valid <= 1'b0;
         result    <= '0;
         result_hi <= '0;
         zero      <= 1'b0;
         ovf       <= 1'b0;
         dz        <= 1'b0;
         err       <= 1'b0;
      end else begin
         if (go_mul || go_div) begin
            cnt <= SHW'(WIDTH - 1);
            opd <= go_mul ? a : b;
            hi  <= '0;
            lo  <= go_mul ? b : a;
         end else if (busy) begin
            cnt <= last ? cnt : cnt - 1'b1;
            hi  <= step_hi;
            lo  <= step_lo;
         end
         if (ld_single) begin
            out_valid <= 1'b1;
            result    <= alu_res;
            result_hi <= alu_hi;
            zero      <= alu_zero;
            ovf       <= alu_ovf;
            dz        <= alu_dz;
            err       <= alu_err;
         end else if (done) begin
            out_valid <= 1'b1;
            result    <= step_lo;
            result_hi <= step_hi;
            zero      <= (step_lo == '0);
            ovf       <= 1'b0;
            dz        <= 1'b0;
            err       <= 1'b0;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_mdu.sv
// Directed bench for alu_mdu: single-cycle ops, mul/div latency,
// backpressure, async reset mid-multiply and illegal opcodes.
module tb_alu_mdu;

   logic        clk, rst_n;
   logic        in_valid, in_ready;
   logic [3:0]  op;
   logic [31:0] a, b;
   logic        out_valid, out_ready;
   logic [31:0] result, result_hi;
   logic        zero, ovf, dz, err, busy;

   int checks = 0;
   int errors = 0;

   alu_mdu #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a(a), .b(b),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .result_hi(result_hi),
      .zero(zero), .ovf(ovf), .dz(dz), .err(err), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [3:0] o, input logic [31:0] x,
                        input logic [31:0] y);
      op = o;
      a = x;
      b = y;
      in_valid = 1'b1;
      #1;
      chk("issue_ready", {31'b0, in_ready}, 32'd1);
      step();
      in_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      in_valid = 1'b0;
      op = 4'h0;
      a = '0;
      b = '0;
      out_ready = 1'b1;
      repeat (3) step();
      chk("rst_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      rst_n = 1'b1;
      chk("rst_ready", {31'b0, in_ready}, 32'd1);

      // signed overflow on add, then single-cycle valid pulse
      issue(4'h0, 32'h7FFF_FFFF, 32'd1);
      chk("add_res", result, 32'h8000_0000);
      chk("add_ovf", {31'b0, ovf}, 32'd1);
      chk("add_zero", {31'b0, zero}, 32'd0);
      chk("add_valid", {31'b0, out_valid}, 32'd1);
      step();
      chk("add_valid_drop", {31'b0, out_valid}, 32'd0);

      issue(4'h1, 32'd5, 32'd5);
      chk("sub_res", result, 32'd0);
      chk("sub_zero", {31'b0, zero}, 32'd1);
      chk("sub_ovf", {31'b0, ovf}, 32'd0);
      issue(4'h1, 32'h8000_0000, 32'd1);
      chk("sub_ovf_res", result, 32'h7FFF_FFFF);
      chk("sub_ovf_flag", {31'b0, ovf}, 32'd1);

      issue(4'h4, 32'h1234, 32'h1234);
      chk("cmp_res", result, 32'h1234);
      chk("cmp_zero", {31'b0, zero}, 32'd1);
      issue(4'hB, 32'h8000_0000, 32'd4);
      chk("sra", result, 32'hF800_0000);
      issue(4'hA, 32'h8000_0000, 32'd4);
      chk("srl", result, 32'h0800_0000);
      issue(4'h9, 32'h0000_0003, 32'd31);
      chk("sll", result, 32'h8000_0000);
      issue(4'h7, 32'hFFFF_FFFF, 32'd1);
      chk("slt", result, 32'd1);
      issue(4'h8, 32'hFFFF_FFFF, 32'd1);
      chk("sltu", result, 32'd0);
      issue(4'h6, 32'h0F0F_0000, 32'h0000_00FF);
      chk("nor", result, 32'hF0F0_FF00);
      issue(4'h5, 32'hFF00_FF00, 32'h0FF0_0FF0);
      chk("xor", result, 32'hF0F0_F0F0);

      // multiply with a second request held through the busy window
      op = 4'hC;
      a = 32'hFFFF_FFFF;
      b = 32'd2;
      in_valid = 1'b1;
      #1;
      chk("mul_ready", {31'b0, in_ready}, 32'd1);
      step();
      op = 4'h0;
      a = 32'd1;
      b = 32'd1;
      for (int k = 0; k < 32; k++) begin
         chk("mul_busy", {31'b0, busy}, 32'd1);
         chk("mul_inready", {31'b0, in_ready}, 32'd0);
         chk("mul_early_valid", {31'b0, out_valid}, 32'd0);
         step();
      end
      chk("mul_valid", {31'b0, out_valid}, 32'd1);
      chk("mul_lo", result, 32'hFFFF_FFFE);
      chk("mul_hi", result_hi, 32'd1);
      chk("mul_busy_end", {31'b0, busy}, 32'd0);
      step();
      in_valid = 1'b0;
      chk("held_add", result, 32'd2);
      chk("held_add_hi", result_hi, 32'd0);

      issue(4'hD, 32'd100, 32'd7);
      for (int k = 0; k < 31; k++) begin
         chk("div_early_valid", {31'b0, out_valid}, 32'd0);
         step();
      end
      step();
      chk("div_valid", {31'b0, out_valid}, 32'd1);
      chk("div_q", result, 32'd14);
      chk("div_r", result_hi, 32'd2);
      chk("div_dz", {31'b0, dz}, 32'd0);

      issue(4'hD, 32'd9, 32'd0);
      chk("dz_valid", {31'b0, out_valid}, 32'd1);
      chk("dz_res", result, 32'hFFFF_FFFF);
      chk("dz_hi", result_hi, 32'd9);
      chk("dz_flag", {31'b0, dz}, 32'd1);
      step();

      // backpressure, then replace result on the draining edge
      out_ready = 1'b0;
      issue(4'h0, 32'd1, 32'd2);
      for (int k = 0; k < 5; k++) begin
         chk("bp_res", result, 32'd3);
         chk("bp_valid", {31'b0, out_valid}, 32'd1);
         chk("bp_inready", {31'b0, in_ready}, 32'd0);
         step();
      end
      op = 4'h3;
      a = 32'hF0;
      b = 32'h3C;
      in_valid = 1'b1;
      out_ready = 1'b1;
      #1;
      chk("bp_comb_ready", {31'b0, in_ready}, 32'd1);
      step();
      in_valid = 1'b0;
      chk("bp_and", result, 32'h30);
      chk("bp_nobubble", {31'b0, out_valid}, 32'd1);

      // asynchronous reset during a multiply
      issue(4'hC, 32'd3, 32'd5);
      repeat (9) step();
      chk("mid_busy", {31'b0, busy}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_result", result, 32'd0);
      chk("arst_hi", result_hi, 32'd0);
      chk("arst_valid", {31'b0, out_valid}, 32'd0);
      chk("arst_busy", {31'b0, busy}, 32'd0);
      chk("arst_zero", {31'b0, zero}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("arst_ready", {31'b0, in_ready}, 32'd1);
      issue(4'h2, 32'hA, 32'h5);
      chk("or_res", result, 32'hF);
      chk("or_valid", {31'b0, out_valid}, 32'd1);
      issue(4'hF, 32'h1234, 32'h5678);
      chk("ill_err", {31'b0, err}, 32'd1);
      chk("ill_res", result, 32'd0);
      chk("ill_zero", {31'b0, zero}, 32'd1);
      chk("ill_hi", result_hi, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
Parametrised successor to the single-function execute ALU for the MIPS datapath. Adds a valid/ready handshake on input and output, a wider opcode set (logic, compare, shifts, set-less-than) and iterative unsigned multiply/divide units. Sits in the EX stage. The pipeline control stalls on in_ready and drains results on out_valid/out_ready.

Parameters:
WIDTH, 32, operand/result width in bits; must be >= 4 and a power of two
SHW, $clog2(WIDTH), shift-amount bits taken from b[SHW-1:0]

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operation request
in_ready  out  1  block can accept an operation this cycle
op  in  4  opcode (see Behaviour)
a  in  WIDTH  operand A
b  in  WIDTH  operand B
out_valid  out  1  result/flags valid
out_ready  in  1  consumer takes the result this cycle
result  out  WIDTH  primary result (product low / quotient)
result_hi  out  WIDTH  product high / remainder; 0 for other ops
zero  out  1  result==0 (CMP: a==b)
ovf  out  1  signed overflow (ADD/SUB only, else 0)
dz  out  1  divide by zero (DIVU only)
err  out  1  illegal opcode
busy  out  1  multi-cycle operation in progress

Behaviour:
- Opcodes: 0 ADD, 1 SUB, 2 OR, 3 AND, 4 CMP (result=a, zero=(a==b)), 5 XOR, 6 NOR, 7 SLT signed, 8 SLTU, 9 SLL, A SRL, B SRA, C MULU, D DIVU, E/F illegal.
- Shift amount: b[SHW-1:0]. SRA replicates a[WIDTH-1]. SLT/SLTU produce 0 or 1 in result[0].
- ADD/SUB wrap modulo 2^WIDTH. ovf is set when the operand signs make the signed result unrepresentable.
- Accept: in_valid && in_ready at edge E. Operands and op are captured at E and must not be re-sampled afterwards.
- in_ready is asserted when state==IDLE && (!out_valid || out_ready). In this condition in_ready is combinational in out_ready.
- FSM states:
  - IDLE: on accept of a single-cycle op (0-B, E, F), load outputs at E, set out_valid, stay in IDLE.
  - IDLE on accept of MULU: go to MUL. On accept of DIVU with b!=0: go to DIV. DIVU with b==0 is handled as single-cycle.
  - MUL: shift-add, one bit per cycle. Counter runs WIDTH-1 down to 0. At the edge where the counter hits 0, load result/result_hi, set out_valid and go to IDLE. The result is visible after edge E+WIDTH.
  - DIV: restoring division, one bit per cycle, same counter and latency as MUL.
- busy=1 in MUL/DIV. in_ready=0 in MUL/DIV.
- Divide by zero: result={WIDTH{1}}, result_hi=a, dz=1, latency 1.
- Illegal op: result=0, result_hi=0, err=1, zero=1, latency 1.
- Output hold: while out_valid && !out_ready, all outputs stay stable. out_valid clears on out_ready unless a new accept occurs on the same edge; in that case the new result replaces the old one with no bubble.
- Flags are registered together with result. On each new result, all flags not owned by the op are 0.
- Reset (asynchronous, any time including mid MUL/DIV): state=IDLE, counter=0, out_valid=0, result=0, result_hi=0, zero=0, ovf=0, dz=0, err=0, busy=0. Any in-flight operation is discarded. in_ready=1 from the first cycle after rst_n deasserts.
- No X propagation: partial-product, remainder and quotient registers are reset to 0.

Test Plan:
1. WIDTH=32. ADD a=0x7FFFFFFF b=1, out_ready=1 -> after the accept edge: result=0x80000000, ovf=1, zero=0, out_valid=1 for one cycle. SUB a=5 b=5 -> result=0, zero=1, ovf=0.
2. CMP a=0x1234 b=0x1234 -> result=0x1234, zero=1. SRA a=0x80000000 b=4 -> 0xF8000000. SLT a=0xFFFFFFFF b=1 -> 1. SLTU with the same operands -> 0.
3. MULU a=0xFFFFFFFF b=2 -> busy=1 and in_ready=0 for 32 cycles, out_valid exactly 32 edges after accept, result=0xFFFFFFFE, result_hi=1. A second in_valid held during this window is not accepted until IDLE.
4. DIVU a=100 b=7 -> result=14, result_hi=2, latency 32. DIVU a=9 b=0 -> result=0xFFFFFFFF, result_hi=9, dz=1, latency 1.
5. Backpressure: out_ready=0, issue ADD 1+2 -> result=3 held stable for 5 cycles, in_ready=0 throughout. Raise out_ready with a pending in_valid (AND 0xF0,0x3C) on the same edge -> result becomes 0x30 with no idle cycle.
6. Assert rst_n=0 at cycle 10 of a MULU -> all outputs 0 immediately (asynchronous). Release reset, issue OR 0xA,0x5 -> result=0xF after one edge. Opcode 0xF -> err=1, result=0.
